// File: rtl/bram_1p_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : bram_1p_arbiter_if
//  Description : Bundle of the requester, clear-control and BRAM-side signals
//                of bram_1p_arbiter.
//                slave  - arbiter view: takes requests, clear_i, mem_data_i;
//                         drives grants, read returns, status, BRAM controls.
//                master - environment view: requesters plus the attached BRAM.
//  Revision    : 1.0  initial release
// ============================================================================
interface bram_1p_arbiter_if #(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 10
);
  // Requester A / B
  logic                     a_req_i,    b_req_i;
  logic                     a_we_i,     b_we_i;
  logic [RAM_ADDR_BITS-1:0] a_addr_i,   b_addr_i;
  logic [RAM_WIDTH-1:0]     a_data_i,   b_data_i;
  logic                     a_gnt_o,    b_gnt_o;
  logic                     a_rvalid_o, b_rvalid_o;
  logic [RAM_WIDTH-1:0]     rdata_o;
  // Clear control
  logic                     clear_i;
  logic                     busy_o;
  logic                     done_o;
  // BRAM port
  logic                     mem_en_o;
  logic                     mem_we_o;
  logic [RAM_ADDR_BITS-1:0] mem_addr_o;
  logic [RAM_WIDTH-1:0]     mem_data_o;
  logic [RAM_WIDTH-1:0]     mem_data_i;

  modport slave (
    input  a_req_i, b_req_i, a_we_i, b_we_i, a_addr_i, b_addr_i,
           a_data_i, b_data_i, clear_i, mem_data_i,
    output a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o, rdata_o,
           busy_o, done_o, mem_en_o, mem_we_o, mem_addr_o, mem_data_o
  );

  modport master (
    output a_req_i, b_req_i, a_we_i, b_we_i, a_addr_i, b_addr_i,
           a_data_i, b_data_i, clear_i, mem_data_i,
    input  a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o, rdata_o,
           busy_o, done_o, mem_en_o, mem_we_o, mem_addr_o, mem_data_o
  );
endinterface
`default_nettype wire

// File: rtl/bram_1p_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bram_1p_arbiter
//  Description : Round-robin arbiter sharing one single-port BRAM between two
//                requesters, with a zero-fill (clear) sequence.
//  Ports       : clk_i  - clock, all state changes on posedge
//                rst_i  - asynchronous active-high reset
//                bus    - bram_1p_arbiter_if.slave: requests/grants, read
//                         return, clear/busy/done, BRAM controls and data
//  Revision    : 1.0  initial release
// ============================================================================
module bram_1p_arbiter #(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 10
) (
  input  wire logic          clk_i,
  input  wire logic          rst_i,
  bram_1p_arbiter_if.slave   bus
);

  localparam logic [0:0] ARB   = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  localparam logic [RAM_ADDR_BITS-1:0] LAST_ADDR = '1;

  logic [0:0]               state;
  logic [RAM_ADDR_BITS-1:0] cnt;
  logic                     prefer_a;   // 1: A wins a tie
  logic                     a_rvalid;
  logic                     b_rvalid;
  logic                     done;

  logic                     arb_active;
  logic                     a_gnt;
  logic                     b_gnt;
  logic                     in_clear;

  // Grants only in ARB, never in the cycle that launches a clear, and never
  // while reset is held (reset is asynchronous, so gate combinationally too).
  assign arb_active = (state == ARB) && !bus.clear_i && !rst_i;
  assign a_gnt      = arb_active && bus.a_req_i && (!bus.b_req_i ||  prefer_a);
  assign b_gnt      = arb_active && bus.b_req_i && (!bus.a_req_i || !prefer_a);
  assign in_clear   = (state == CLEAR) && !rst_i;

  always_comb begin
    bus.mem_en_o   = 1'b0;
    bus.mem_we_o   = 1'b0;
    bus.mem_addr_o = bus.a_addr_i;
    bus.mem_data_o = bus.a_data_i;
    if (in_clear) begin
      bus.mem_en_o   = 1'b1;
      bus.mem_we_o   = 1'b1;
      bus.mem_addr_o = cnt;
      bus.mem_data_o = {RAM_WIDTH{1'b0}};
    end else if (a_gnt) begin
      bus.mem_en_o   = 1'b1;
      bus.mem_we_o   = bus.a_we_i;
    end else if (b_gnt) begin
      bus.mem_en_o   = 1'b1;
      bus.mem_we_o   = bus.b_we_i;
      bus.mem_addr_o = bus.b_addr_i;
      bus.mem_data_o = bus.b_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ARB;
      cnt      <= '0;
      prefer_a <= 1'b1;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      done     <= 1'b0;
    end else begin
      // Read returns are launched from this cycle's grant regardless of any
      // clear request arriving next cycle.
      a_rvalid <= a_gnt && !bus.a_we_i;
      b_rvalid <= b_gnt && !bus.b_we_i;
      done     <= 1'b0;
      if (a_gnt || b_gnt) begin
        prefer_a <= b_gnt;
      end
      case (state)
        ARB: begin
          if (bus.clear_i) begin
            state <= CLEAR;
            cnt   <= '0;
          end
        end
        CLEAR: begin
          // Counter parks at LAST_ADDR; the next clear reloads it.
          if (cnt == LAST_ADDR) begin
            state <= ARB;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  assign bus.a_gnt_o    = a_gnt;
  assign bus.b_gnt_o    = b_gnt;
  assign bus.a_rvalid_o = a_rvalid;
  assign bus.b_rvalid_o = b_rvalid;
  assign bus.rdata_o    = bus.mem_data_i;
  assign bus.busy_o     = (state == CLEAR);
  assign bus.done_o     = done;

endmodule
`default_nettype wire

// File: tb/tb_bram_1p_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bram_1p_arbiter
//  Description : Directed self-checking bench for bram_1p_arbiter with a
//                16-entry registered-read, no-change-write BRAM model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bram_1p_arbiter;

  localparam int W  = 8;
  localparam int AB = 4;
  localparam int DEPTH = 1 << AB;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  int total  = 0;
  int passes = 0;

  bram_1p_arbiter_if #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) bus ();

  bram_1p_arbiter #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // BRAM model: 1-cycle registered read, output holds during writes.
  logic [W-1:0] mem [DEPTH];
  always @(posedge clk_i) begin
    if (bus.mem_en_o) begin
      if (bus.mem_we_o) mem[bus.mem_addr_o] <= bus.mem_data_o;
      else              bus.mem_data_i      <= mem[bus.mem_addr_o];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.a_req_i = 0; bus.b_req_i = 0; bus.a_we_i = 0; bus.b_we_i = 0;
    bus.a_addr_i = '0; bus.b_addr_i = '0; bus.a_data_i = '0; bus.b_data_i = '0;
    bus.clear_i = 0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #1;
  endtask

  initial begin
    bit seen_done;
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'hFF;
    bus.a_req_i = 1;
    step();
    // ---- reset state
    check("rst_a_gnt",  bus.a_gnt_o, 0);
    check("rst_mem_en", bus.mem_en_o, 0);
    check("rst_busy",   bus.busy_o, 0);
    check("rst_done",   bus.done_o, 0);
    check("rst_rvalid", {bus.a_rvalid_o, bus.b_rvalid_o}, 0);
    rst_i = 0;
    // ---- write then read A
    bus.a_we_i = 1; bus.a_addr_i = 4'd5; bus.a_data_i = 8'hA5;
    #1;
    check("wr_a_gnt",    bus.a_gnt_o, 1);
    check("wr_b_gnt",    bus.b_gnt_o, 0);
    check("wr_mem_ctl",  {bus.mem_en_o, bus.mem_we_o}, 2'b11);
    check("wr_mem_addr", bus.mem_addr_o, 5);
    check("wr_mem_data", bus.mem_data_o, 8'hA5);
    step();
    bus.a_we_i = 0;
    #1;
    check("rd_a_gnt",    bus.a_gnt_o, 1);
    check("rd_mem_ctl",  {bus.mem_en_o, bus.mem_we_o}, 2'b10);
    check("wr_no_rvalid", bus.a_rvalid_o, 0);
    step();
    bus.a_req_i = 0;
    #1;
    check("rd_rvalid", {bus.a_rvalid_o, bus.b_rvalid_o}, 2'b10);
    check("rd_rdata",  bus.rdata_o, 8'hA5);
    check("idle_en",   {bus.mem_en_o, bus.mem_we_o}, 0);
    step();
    check("rvalid_pulse", bus.a_rvalid_o, 0);

    // ---- both requesting from reset: A,B,A,B
    do_reset();
    bus.a_req_i = 1; bus.b_req_i = 1; bus.a_we_i = 1; bus.b_we_i = 1;
    bus.a_addr_i = 4'd1; bus.b_addr_i = 4'd2; bus.a_data_i = 8'h11; bus.b_data_i = 8'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_gnt",  {bus.a_gnt_o, bus.b_gnt_o}, (i % 2 == 0) ? 2'b10 : 2'b01);
      check("rr_addr", bus.mem_addr_o, (i % 2 == 0) ? 1 : 2);
      step();
    end

    // ---- B alone three cycles, then both -> A
    do_reset();
    idle_inputs();
    bus.b_req_i = 1; bus.b_addr_i = 4'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("b_alone", {bus.a_gnt_o, bus.b_gnt_o}, 2'b01);
      step();
    end
    bus.a_req_i = 1; bus.a_addr_i = 4'd5;
    #1;
    check("after_b_both", {bus.a_gnt_o, bus.b_gnt_o}, 2'b10);
    step();
    // idle cycle must not move the pointer: B still favoured
    bus.a_req_i = 0; bus.b_req_i = 0;
    #1;
    check("idle_no_gnt", {bus.a_gnt_o, bus.b_gnt_o}, 2'b00);
    step();
    bus.a_req_i = 1; bus.b_req_i = 1;
    #1;
    check("ptr_hold", {bus.a_gnt_o, bus.b_gnt_o}, 2'b01);
    step();

    // ---- clear sequence, requests held throughout
    bus.clear_i = 1;
    #1;
    check("clr_req_gnt", {bus.a_gnt_o, bus.b_gnt_o}, 2'b00);
    check("clr_req_en",  bus.mem_en_o, 0);
    step();
    bus.clear_i = 0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.clear_i = (i == 3);   // must be ignored
      #1;
      check("clr_busy", bus.busy_o, 1);
      check("clr_gnt",  {bus.a_gnt_o, bus.b_gnt_o}, 2'b00);
      check("clr_ctl",  {bus.mem_en_o, bus.mem_we_o}, 2'b11);
      check("clr_addr", bus.mem_addr_o, i);
      check("clr_data", bus.mem_data_o, 0);
      check("clr_done", bus.done_o, 0);
      step();
    end
    idle_inputs();
    #1;
    check("clr_end_busy", bus.busy_o, 0);
    check("clr_end_done", bus.done_o, 1);
    bus.a_req_i = 1; bus.a_addr_i = 4'd5;
    #1;
    check("post_clr_gnt", bus.a_gnt_o, 1);
    step();
    bus.a_addr_i = 4'd2;
    #1;
    check("done_pulse", bus.done_o, 0);
    check("post_clr_rv5", bus.a_rvalid_o, 1);
    check("post_clr_rd5", bus.rdata_o, 0);
    step();
    bus.a_req_i = 0;
    #1;
    check("post_clr_rd2", bus.rdata_o, 0);
    step();

    // ---- reset mid-clear at cycle 7
    bus.clear_i = 1;
    step();
    bus.clear_i = 0;
    for (int i = 0; i < 7; i++) step();
    check("mid_addr", bus.mem_addr_o, 7);
    check("mid_busy", bus.busy_o, 1);
    #2;
    rst_i = 1;
    #1;
    check("abort_busy", bus.busy_o, 0);
    check("abort_en",   bus.mem_en_o, 0);
    step();
    rst_i = 0;
    bus.a_req_i = 1; bus.a_addr_i = 4'd3;
    #1;
    check("abort_gnt", bus.a_gnt_o, 1);
    step();
    bus.a_req_i = 0;
    seen_done = 0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      if (bus.done_o) seen_done = 1;
      step();
    end
    check("abort_no_done", seen_done, 0);

    // ---- read to B then clear next cycle
    bus.b_req_i = 1; bus.b_we_i = 0; bus.b_addr_i = 4'd2;
    #1;
    check("b_rd_gnt", bus.b_gnt_o, 1);
    step();
    bus.b_req_i = 0;
    bus.clear_i = 1;
    #1;
    check("b_rv_in_clr", bus.b_rvalid_o, 1);
    check("b_clr_busy0", bus.busy_o, 0);
    check("b_clr_en0",   bus.mem_en_o, 0);
    step();
    bus.clear_i = 0;
    check("b_clr_busy1", bus.busy_o, 1);
    check("b_clr_addr0", bus.mem_addr_o, 0);
    check("b_rv_drop",   bus.b_rvalid_o, 0);
    seen_done = 0;
    for (int i = 0; i < DEPTH + 4 && !seen_done; i++) begin
      step();
      if (bus.done_o) seen_done = 1;
    end
    check("b_clr_done", seen_done, 1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
`default_nettype wire
